// File: rtl/time_display_scan.sv
// time_display_scan
// Reader side of the HH:MM:SS BCD time counter. Scans the six BCD digits onto
// an 8-digit common-anode multiplexed 7-segment display, one digit at a time.
// Positions 6 and 7 are driven blank so every digit gets the same duty cycle.
// The field selected by blink_sel flashes at BLINK_HZ.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   h_tens .. s_units : BCD time digits (codes 10..15 show a dash)
//   blink_sel  : field to flash, 00 none, 01 hours, 10 minutes, 11 seconds
//   display_en : 1 = display on, 0 = all anodes off (counters keep running)
//   an         : anode enables, active-low, one-hot-low while scanning
//   seg        : segments, active-low, bit0 = a .. bit6 = g
//   dp         : decimal point, active-low
module time_display_scan #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int REFRESH_HZ      = 1000,
  parameter int BLINK_HZ        = 2,
  parameter int BLANK_LEAD_ZERO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] h_tens,
  input  logic [3:0] h_units,
  input  logic [3:0] m_tens,
  input  logic [3:0] m_units,
  input  logic [3:0] s_tens,
  input  logic [3:0] s_units,
  input  logic [1:0] blink_sel,
  input  logic       display_en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV  = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int BDIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int BW   = (BDIV > 1) ? $clog2(BDIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BDIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_bphase;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_bwrap;
  logic [3:0]    w_digit;
  logic          w_pos_blank;
  logic [1:0]    w_field;
  logic          w_blinked;
  logic          w_lead_blank;
  logic [7:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  function automatic logic [6:0] f_bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // invalid BCD shows a dash
    endcase
    return s;
  endfunction

  assign w_tick  = (r_presc == PMAX);
  assign w_bwrap = (r_bcnt == BMAX);

  always_comb begin
    w_digit     = 4'd0;
    w_pos_blank = 1'b0;
    w_field     = 2'b00;
    case (r_idx)
      3'd0: begin w_digit = s_units; w_field = 2'b11; end
      3'd1: begin w_digit = s_tens;  w_field = 2'b11; end
      3'd2: begin w_digit = m_units; w_field = 2'b10; end
      3'd3: begin w_digit = m_tens;  w_field = 2'b10; end
      3'd4: begin w_digit = h_units; w_field = 2'b01; end
      3'd5: begin w_digit = h_tens;  w_field = 2'b01; end
      default: w_pos_blank = 1'b1;
    endcase
  end

  // Positions 6/7 carry field 00, so they can never match a non-zero selection.
  assign w_blinked    = r_bphase && (blink_sel != 2'b00) && (blink_sel == w_field);
  assign w_lead_blank = (BLANK_LEAD_ZERO != 0) && (r_idx == 3'd5) && (h_tens == 4'd0);

  always_comb begin
    w_an  = display_en ? ~(8'd1 << r_idx) : 8'hFF;
    w_seg = (w_pos_blank || w_blinked || w_lead_blank) ? SEG_BLANK : f_bcd_to_seg(w_digit);
    // Separators after hours and minutes; a blinked digit hides its point too.
    w_dp  = !((r_idx == 3'd2 || r_idx == 3'd4) && !w_blinked);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc  <= '0;
      r_idx    <= 3'd0;
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
      r_an     <= 8'hFF;
      r_seg    <= SEG_BLANK;
      r_dp     <= 1'b1;
    end else begin
      // Refresh prescaler and scan index
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= r_idx + 3'd1;
      // Blink generator, independent of the scan tick
      r_bcnt <= w_bwrap ? '0 : r_bcnt + 1'b1;
      if (w_bwrap) r_bphase <= ~r_bphase;
      // Output stage: pins follow current state with one cycle of latency
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_time_display_scan.sv
module tb_time_display_scan;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int REFRESH_HZ  = 100;
  localparam int BLINK_HZ    = 25;
  localparam int DIV         = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int BDIV        = CLK_FREQ_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] h_tens, h_units, m_tens, m_units, s_tens, s_units;
  logic [1:0] blink_sel;
  logic       display_en;
  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;

  int checks = 0;
  int errors = 0;
  int k = 0;  // rising edges seen since reset release

  time_display_scan #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .REFRESH_HZ(REFRESH_HZ),
    .BLINK_HZ(BLINK_HZ), .BLANK_LEAD_ZERO(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .h_tens(h_tens), .h_units(h_units), .m_tens(m_tens), .m_units(m_units),
    .s_tens(s_tens), .s_units(s_units),
    .blink_sel(blink_sel), .display_en(display_en),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  time_display_scan #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .REFRESH_HZ(REFRESH_HZ),
    .BLINK_HZ(BLINK_HZ), .BLANK_LEAD_ZERO(1)
  ) u_dut_lz (
    .clk(clk), .rst(rst),
    .h_tens(h_tens), .h_units(h_units), .m_tens(m_tens), .m_units(m_units),
    .s_tens(s_tens), .s_units(s_units),
    .blink_sel(blink_sel), .display_en(display_en),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) k = 0;
    else      k = k + 1;
  end

  logic [6:0] seg_tab [16];

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } scan_vec_t;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  scan_vec_t tbl_scan [9];
  dec_vec_t  tbl_dec  [16];

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (k=%0d t=%0t)", name, act, req, k, $time);
    end
  endtask

  // Reference: after edge kk the pins show the state reached after kk-1 edges
  // combined with the inputs present at edge kk.
  function automatic void model(input int kk, input bit blz,
                                output logic [7:0] ean, output logic [6:0] eseg,
                                output logic edp);
    int idx, ph;
    logic [3:0] dig [6];
    bit blinked, blank;
    if (kk == 0) begin
      ean = 8'hFF; eseg = 7'h7F; edp = 1'b1;
      return;
    end
    idx = ((kk - 1) / DIV) % 8;
    ph  = ((kk - 1) / BDIV) % 2;
    dig[0] = s_units; dig[1] = s_tens; dig[2] = m_units;
    dig[3] = m_tens;  dig[4] = h_units; dig[5] = h_tens;
    blinked = (ph == 1) && (idx < 6) && (blink_sel != 0) && (int'(blink_sel) == 3 - idx / 2);
    blank   = (idx >= 6) || (blz && idx == 5 && h_tens == 0);
    ean  = display_en ? ~(8'd1 << idx) : 8'hFF;
    eseg = (blank || blinked) ? 7'h7F : seg_tab[dig[idx < 6 ? idx : 0]];
    edp  = ((idx == 2 || idx == 4) && !blinked) ? 1'b0 : 1'b1;
  endfunction

  task automatic check_model();
    logic [7:0] ea; logic [6:0] es; logic ed;
    model(k, 1'b0, ea, es, ed);
    cmp("an", an0, ea); cmp("seg", {1'b0, seg0}, {1'b0, es}); cmp("dp", {7'd0, dp0}, {7'd0, ed});
    model(k, 1'b1, ea, es, ed);
    cmp("an_lz", an1, ea); cmp("seg_lz", {1'b0, seg1}, {1'b0, es}); cmp("dp_lz", {7'd0, dp1}, {7'd0, ed});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    step(2);
    cmp("reset_an", an0, 8'hFF);
    cmp("reset_seg", {1'b0, seg0}, 8'h7F);
    cmp("reset_dp", {7'd0, dp0}, 8'h01);
    rst = 1'b1;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    h_tens = 4'(hh / 10); h_units = 4'(hh % 10);
    m_tens = 4'(mm / 10); m_units = 4'(mm % 10);
    s_tens = 4'(ss / 10); s_units = 4'(ss % 10);
  endtask

  initial begin
    int nb, bad, nb0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    tbl_scan = '{'{8'hFE, 7'h02, 1'b1}, '{8'hFD, 7'h12, 1'b1}, '{8'hFB, 7'h19, 1'b0},
                 '{8'hF7, 7'h30, 1'b1}, '{8'hEF, 7'h24, 1'b0}, '{8'hDF, 7'h79, 1'b1},
                 '{8'hBF, 7'h7F, 1'b1}, '{8'h7F, 7'h7F, 1'b1}, '{8'hFE, 7'h02, 1'b1}};
    for (int c = 0; c < 16; c++) begin
      tbl_dec[c].code = 4'(c);
      tbl_dec[c].seg  = (c < 10) ? seg_tab[c] : 7'h3F;
    end
    tbl_dec[0].seg = 7'h40; tbl_dec[8].seg = 7'h00; tbl_dec[9].seg = 7'h10;

    set_time(12, 34, 56);
    blink_sel  = 2'b00;
    display_en = 1'b1;

    // Reset and scan order
    do_reset();
    step(5);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step(DIV);
      cmp("scan_an", an0, tbl_scan[i].an);
      cmp("scan_seg", {1'b0, seg0}, {1'b0, tbl_scan[i].seg});
      cmp("scan_dp", {7'd0, dp0}, {7'd0, tbl_scan[i].dp});
    end

    // Decoder sweep on digit 0
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 8) step(8 * DIV - 8);
      s_units = tbl_dec[c].code;
      step(1);
      cmp("dec_an", an0, 8'hFE);
      cmp("dec_seg", {1'b0, seg0}, {1'b0, tbl_dec[c].seg});
    end
    s_units = 4'd6;

    // Blink minutes, then no blink
    do_reset();
    blink_sel = 2'b10;
    nb = 0; bad = 0;
    for (int i = 0; i < 320; i++) begin
      step(1);
      if ((an0 == 8'hFB || an0 == 8'hF7) && seg0 == 7'h7F) nb++;
      if ((an0 == 8'hFE || an0 == 8'hFD || an0 == 8'hEF || an0 == 8'hDF) && seg0 == 7'h7F) bad++;
    end
    cmp("blink_min_blanked", {7'd0, nb > 0}, 8'h01);
    cmp("blink_other_kept", 8'(bad), 8'h00);
    blink_sel = 2'b00;
    nb0 = 0;
    for (int i = 0; i < 160; i++) begin
      step(1);
      if ((an0 == 8'hFB || an0 == 8'hF7) && seg0 == 7'h7F) nb0++;
    end
    cmp("blink_none", 8'(nb0), 8'h00);

    // display_en toggle
    step(13);
    display_en = 1'b0;
    step(1);
    cmp("disp_off_an", an0, 8'hFF);
    step(25);
    display_en = 1'b1;
    step(1);
    cmp("disp_on_not_restart", {7'd0, an0 != 8'hFE}, 8'h01);
    step(20);

    // Asynchronous reset mid-scan at index 5
    do_reset();
    step(5 * DIV + 5);
    cmp("pre_async_an", an0, 8'hDF);
    #2 rst = 1'b0;
    #1;
    cmp("async_an", an0, 8'hFF);
    cmp("async_seg", {1'b0, seg0}, 8'h7F);
    cmp("async_dp", {7'd0, dp0}, 8'h01);
    step(2);
    rst = 1'b1;
    step(1);
    cmp("post_async_an", an0, 8'hFE);

    // Leading-zero blanking
    set_time(5, 0, 0);
    do_reset();
    step(5 * DIV + 5);
    cmp("lz_seg_blank", {1'b0, seg1}, 8'h7F);
    cmp("nolz_seg_zero", {1'b0, seg0}, 8'h40);
    set_time(15, 0, 0);
    step(1);
    cmp("lz_seg_one", {1'b0, seg1}, 8'h79);
    cmp("nolz_seg_one", {1'b0, seg0}, 8'h79);

    // Randomised run against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        h_tens  = 4'($urandom_range(0, 15)); h_units = 4'($urandom_range(0, 15));
        m_tens  = 4'($urandom_range(0, 15)); m_units = 4'($urandom_range(0, 15));
        s_tens  = 4'($urandom_range(0, 15)); s_units = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) blink_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) display_en = ~display_en;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
